// File: rtl/div_pkg.sv
// Shared constants for the clock-enable divider controller: widths, reset ratio and FSM encodings.
package div_pkg;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned DEFAULT_DIV_DEF = 2;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_STOP = 2'd0;
    localparam div_state_t ST_RUN  = 2'd1;
    localparam div_state_t ST_PEND = 2'd2;

endpackage

// File: rtl/div_cnt.sv
// Wrap counter: counts 0..div-1 while run is high, held at 0 otherwise.
module div_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_c;

    // div is never 0, so div-1 cannot underflow
    assign last_c = div - CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || clr) begin
            cnt_d = '0;
        end else if (cnt_q == last_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = run && (cnt_q == last_c);

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run/stop and ratio-change controller for the clock-enable divider; ratio changes while
// running are parked in a shadow register and applied only at a terminal-count boundary.
module div_ratio_ctrl
    import div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             out,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             running_c;
    logic             xfer_c;
    logic             zero_c;
    logic             clr_c;
    logic [CNT_W-1:0] cnt_w;
    logic             tc_w;

    assign running_c = (state_q != ST_STOP);
    assign xfer_c    = cfg_valid && ready_q;
    assign zero_c    = (cfg_div == '0);
    // Leaving RUN/PEND must land the counter on 0 at the same edge
    assign clr_c     = running_c && !en;

    div_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (running_c),
        .clr   (clr_c),
        .div   (div_q),
        .cnt   (cnt_w),
        .tc    (tc_w)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        err_d    = xfer_c && zero_c;

        if (tc_w) begin
            out_d = !out_q;
        end

        case (state_q)
            ST_STOP: begin
                if (xfer_c && !zero_c) begin
                    div_d = cfg_div;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                    if (xfer_c && !zero_c) begin
                        div_d = cfg_div;
                    end
                end else if (xfer_c && !zero_c) begin
                    shadow_d = cfg_div;
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!en) begin
                    state_d = ST_STOP;
                    div_d   = shadow_q;
                end else if (tc_w) begin
                    state_d = ST_RUN;
                    div_d   = shadow_q;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        ready_d = (state_d != ST_PEND);
        busy_d  = (state_d != ST_STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STOP;
            div_q    <= CNT_W'(DEFAULT_DIV);
            shadow_q <= '0;
            out_q    <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Terminal-count decode straight from registers, no input-to-output path
    assign tick      = running_c && (cnt_w == (div_q - CNT_W'(1)));
    assign out       = out_q;
    assign cfg_err   = err_q;
    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign cur_div   = div_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed self-checking bench for div_ratio_ctrl with hand-computed expected values.
module tb_div_ratio_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       tick;
    logic       out;
    logic [7:0] cur_div;
    logic       busy;

    int total = 0;
    int bad   = 0;

    div_ratio_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .out       (out),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_tick, input logic e_out,
                           input logic [7:0] e_div, input logic e_busy, input logic e_rdy,
                           input logic e_err);
        chk({tag, ".tick"},  32'(tick),      32'(e_tick));
        chk({tag, ".out"},   32'(out),       32'(e_out));
        chk({tag, ".div"},   32'(cur_div),   32'(e_div));
        chk({tag, ".busy"},  32'(busy),      32'(e_busy));
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(e_rdy));
        chk({tag, ".err"},   32'(cfg_err),   32'(e_err));
    endtask

    logic [5:0] t1_tick;
    logic [5:0] t1_out;
    logic [9:0] t2_tick;
    logic [9:0] t2_out;

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        #12;
        chk_all("reset", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // 1: default ratio 2, ticks in running cycles 2,4,6
        en = 1'b1;
        t1_tick = 6'b101010;
        t1_out  = 6'b001100;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t1.c%0d.tick", i + 1), 32'(tick), 32'(t1_tick[i]));
            chk($sformatf("t1.c%0d.out", i + 1),  32'(out),  32'(t1_out[i]));
        end
        chk("t1.div", 32'(cur_div), 32'd2);
        en = 1'b0;
        step();
        chk_all("t1.stop", 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0);

        // 2: load 5 while stopped, then run
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        chk_all("t2.load", 1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        t2_tick = 10'b1000010000;
        t2_out  = 10'b0000011111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t2.c%0d.tick", i + 1), 32'(tick), 32'(t2_tick[i]));
            chk($sformatf("t2.c%0d.out", i + 1),  32'(out),  32'(t2_out[i]));
        end

        // en falling with a transfer on a tick cycle: direct load, STOP, out toggles
        en = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd6;
        step();
        chk_all("drop_xfer", 1'b0, 1'b1, 8'd6, 1'b0, 1'b1, 1'b0);
        // en rising with a transfer: load 4 and run on the same edge
        en = 1'b1; cfg_div = 8'd4;
        step();
        cfg_valid = 1'b0;
        chk_all("rise_xfer", 1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0);

        // 3: div=4, request 3 at cnt=1
        step();
        chk("t3.c2.tick", 32'(tick), 32'd0);
        cfg_valid = 1'b1; cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0;
        chk_all("t3.pend", 1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t3.tc4", 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("t3.apply", 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0);
        step();
        chk("t3.c6.tick", 32'(tick), 32'd0);
        step();
        chk("t3.c7.tick", 32'(tick), 32'd1);
        step();
        chk_all("t3.c8", 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);

        // 4: zero ratio rejected while running
        cfg_valid = 1'b1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        chk_all("t4.err", 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1);
        step();
        chk_all("t4.tick", 1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);

        // transfer on a tick cycle goes to shadow, applied at the next terminal count
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        chk_all("tkx.pend", 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        step();
        chk("tkx.c12.tick", 32'(tick), 32'd0);
        step();
        chk_all("tkx.tc", 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("tkx.apply", 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0);

        // 5: PEND with shadow 7, drop en off-boundary
        cfg_valid = 1'b1; cfg_div = 8'd7;
        step();
        cfg_valid = 1'b0;
        chk_all("t5.pend", 1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk_all("t5.stop", 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("t5.hold", 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0);

        // 6: async reset in the middle of PEND
        en = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0;
        chk_all("t6.pend", 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t6.async", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("t6.c1", 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("t6.c2", 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("t6.c3", 1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0);

        // div=1: tick every running cycle, out toggles every cycle
        en = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b0;
        chk_all("d1.stop", 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        step();
        chk_all("d1.c1", 1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("d1.c2", 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("d1.c3", 1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("d1.c4", 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
